// File: rtl/param_datapath.sv
// Parametrised processor datapath: general register file, special registers,
// encoded single-bus source mux and a handshaked memory port with timeout.
module param_datapath #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned R0_BA    = 1,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS + 8)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [SEL_W-1:0]      bus_sel,
  input  logic                  ba_out,
  input  logic [NUM_REGS-1:0]   reg_en,
  input  logic                  hi_en,
  input  logic                  lo_en,
  input  logic                  y_en,
  input  logic                  z_en,
  input  logic                  pc_en,
  input  logic                  ir_en,
  input  logic                  mar_en,
  input  logic                  mdr_en,
  input  logic                  out_en,
  input  logic                  inc_pc,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WIDTH-1:0]      c_sext,
  input  logic [WIDTH-1:0]      in_port,
  input  logic [2*WIDTH-1:0]    alu_result,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [WIDTH-1:0]      bus,
  output logic [WIDTH-1:0]      ir,
  output logic [WIDTH-1:0]      out_port,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic                  mem_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SEL_W-1:0] SEL_HI    = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0] SEL_LO    = SEL_W'(NUM_REGS + 1);
  localparam logic [SEL_W-1:0] SEL_ZHI   = SEL_W'(NUM_REGS + 2);
  localparam logic [SEL_W-1:0] SEL_ZLO   = SEL_W'(NUM_REGS + 3);
  localparam logic [SEL_W-1:0] SEL_PC    = SEL_W'(NUM_REGS + 4);
  localparam logic [SEL_W-1:0] SEL_MDR   = SEL_W'(NUM_REGS + 5);
  localparam logic [SEL_W-1:0] SEL_INP   = SEL_W'(NUM_REGS + 6);
  localparam logic [SEL_W-1:0] SEL_CSIGN = SEL_W'(NUM_REGS + 7);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_e;

  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WIDTH-1:0]  hi_q, lo_q, y_q, zhi_q, zlo_q, pc_q, ir_q, out_q;
  logic [ADDR_W-1:0] mar_q;
  logic [WIDTH-1:0]  bus_mux;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  mdr_q, mdr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    bus_mux = '0;
    if (bus_sel < SEL_HI) begin
      bus_mux = regs_q[bus_sel[IDX_W-1:0]];
      if ((R0_BA != 0) && ba_out && (bus_sel == '0)) bus_mux = '0;
    end else begin
      case (bus_sel)
        SEL_HI:    bus_mux = hi_q;
        SEL_LO:    bus_mux = lo_q;
        SEL_ZHI:   bus_mux = zhi_q;
        SEL_ZLO:   bus_mux = zlo_q;
        SEL_PC:    bus_mux = pc_q;
        SEL_MDR:   bus_mux = mdr_q;
        SEL_INP:   bus_mux = in_port;
        SEL_CSIGN: bus_mux = c_sext;
        default:   bus_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[IDX_W'(i)] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      out_q <= '0;
      mar_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (reg_en[IDX_W'(i)]) regs_q[IDX_W'(i)] <= bus_mux;
      if (hi_en)  hi_q  <= bus_mux;
      if (lo_en)  lo_q  <= bus_mux;
      if (y_en)   y_q   <= bus_mux;
      if (ir_en)  ir_q  <= bus_mux;
      if (out_en) out_q <= bus_mux;
      if (mar_en) mar_q <= bus_mux[ADDR_W-1:0];
      if (z_en) begin
        zhi_q <= alu_result[2*WIDTH-1:WIDTH];
        zlo_q <= alu_result[WIDTH-1:0];
      end
      if (pc_en)       pc_q <= bus_mux;
      else if (inc_pc) pc_q <= pc_q + WIDTH'(PC_STEP);
    end
  end

  // MDR lives with the FSM: bus loads only in IDLE, read data only on ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mdr_en) mdr_d = bus_mux;
        if (mem_read && mem_write) begin
          err_d = 1'b1;
        end else if (mem_read) begin
          state_d = RD_WAIT;
          addr_d  = mar_q;
        end else if (mem_write) begin
          state_d = WR_WAIT;
          addr_d  = mar_q;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          if (state_q == RD_WAIT) mdr_d = mem_rdata;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mdr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mdr_q   <= mdr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus       = bus_mux;
  assign alu_a     = bus_mux;
  assign alu_b     = y_q;
  assign ir        = ir_q;
  assign out_port  = out_q;
  assign mem_busy  = (state_q != IDLE);
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = (state_q == WR_WAIT);
  assign mem_addr  = (state_q == IDLE) ? mar_q : addr_q;
  assign mem_wdata = mdr_q;
  assign mem_done  = done_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath: register loads, bus mux, PC, Z pair,
// memory handshake, timeout, conflicting requests and clear behaviour.
module tb_param_datapath;

  localparam int SEL_W = 5;
  localparam int S_HI = 16, S_LO = 17, S_ZHI = 18, S_ZLO = 19;
  localparam int S_PC = 20, S_MDR = 21, S_INP = 22, S_CS = 23;

  logic             clk = 1'b0;
  logic             clr;
  logic [SEL_W-1:0] bus_sel;
  logic             ba_out;
  logic [15:0]      reg_en;
  logic             hi_en, lo_en, y_en, z_en, pc_en, ir_en, mar_en, mdr_en, out_en;
  logic             inc_pc, mem_read, mem_write;
  logic [31:0]      c_sext, in_port;
  logic [63:0]      alu_result;
  logic [31:0]      alu_a, alu_b, bus, ir, out_port;
  logic             mem_req, mem_we;
  logic [8:0]       mem_addr;
  logic [31:0]      mem_wdata, mem_rdata;
  logic             mem_ack, mem_busy, mem_done, mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  param_datapath #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(9), .PC_STEP(1),
                   .TIMEOUT(15), .R0_BA(1)) dut (
    .clk(clk), .clr(clr), .bus_sel(bus_sel), .ba_out(ba_out), .reg_en(reg_en),
    .hi_en(hi_en), .lo_en(lo_en), .y_en(y_en), .z_en(z_en), .pc_en(pc_en),
    .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en), .out_en(out_en),
    .inc_pc(inc_pc), .mem_read(mem_read), .mem_write(mem_write),
    .c_sext(c_sext), .in_port(in_port), .alu_result(alu_result),
    .alu_a(alu_a), .alu_b(alu_b), .bus(bus), .ir(ir), .out_port(out_port),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic see_bus(input int sel, input string tag, input logic [31:0] exp);
    bus_sel = SEL_W'(sel);
    #1;
    chk(tag, bus, exp);
  endtask

  initial begin
    clr = 1'b0; bus_sel = '0; ba_out = 1'b0; reg_en = '0;
    hi_en = 0; lo_en = 0; y_en = 0; z_en = 0; pc_en = 0; ir_en = 0;
    mar_en = 0; mdr_en = 0; out_en = 0; inc_pc = 0; mem_read = 0; mem_write = 0;
    c_sext = '0; in_port = '0; alu_result = '0; mem_rdata = '0; mem_ack = 0;
    step(); step();
    clr = 1'b1;

    // preload everything, then clear
    bus_sel = SEL_W'(S_CS); c_sext = 32'hFFFF_FFF0; reg_en = 16'h0020;
    hi_en = 1; lo_en = 1; y_en = 1; z_en = 1; pc_en = 1; ir_en = 1;
    mar_en = 1; mdr_en = 1; out_en = 1; alu_result = 64'h1111_2222_3333_4444;
    step();
    reg_en = '0; hi_en = 0; lo_en = 0; y_en = 0; z_en = 0; pc_en = 0; ir_en = 0;
    mar_en = 0; mdr_en = 0; out_en = 0;
    chk("preload_ir", ir, 32'hFFFF_FFF0);
    chk("preload_out", out_port, 32'hFFFF_FFF0);
    chk("preload_mar", mem_addr, 9'h1F0);
    chk("preload_mdr", mem_wdata, 32'hFFFF_FFF0);
    clr = 1'b0; step(); clr = 1'b1;
    chk("rst_ir", ir, 0);
    chk("rst_out", out_port, 0);
    chk("rst_y", alu_b, 0);
    chk("rst_mar", mem_addr, 0);
    chk("rst_mdr", mem_wdata, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", mem_busy, 0);
    chk("rst_done", mem_done, 0);
    chk("rst_err", mem_err, 0);
    see_bus(5, "rst_r5", 32'h0);
    see_bus(S_PC, "rst_pc", 32'h0);
    see_bus(S_HI, "rst_hi", 32'h0);
    see_bus(S_ZHI, "rst_zhi", 32'h0);
    see_bus(S_ZLO, "rst_zlo", 32'h0);

    // R5 from CSIGN, then Y from R5
    bus_sel = SEL_W'(S_CS); c_sext = 32'hFFFF_FFF0; reg_en = 16'h0020; step();
    reg_en = '0;
    bus_sel = SEL_W'(5); y_en = 1; step(); y_en = 0;
    chk("y_from_r5", alu_b, 32'hFFFF_FFF0);
    chk("bus_r5", bus, 32'hFFFF_FFF0);

    // R0 base-address gating
    bus_sel = SEL_W'(S_INP); in_port = 32'h1234; reg_en = 16'h0001; step();
    reg_en = '0;
    ba_out = 1; see_bus(0, "r0_ba1", 32'h0);
    ba_out = 0; see_bus(0, "r0_ba0", 32'h1234);
    chk("alu_a_eq_bus", alu_a, 32'h1234);
    see_bus(31, "unused_sel", 32'h0);

    // HI load
    bus_sel = SEL_W'(S_CS); c_sext = 32'h0000_AAAA; hi_en = 1; step(); hi_en = 0;
    see_bus(S_HI, "hi_load", 32'h0000_AAAA);
    see_bus(S_LO, "lo_untouched", 32'h0);

    // PC wrap and priority
    bus_sel = SEL_W'(S_CS); c_sext = 32'hFFFF_FFFF; pc_en = 1; step(); pc_en = 0;
    see_bus(S_PC, "pc_load", 32'hFFFF_FFFF);
    inc_pc = 1; step(); inc_pc = 0;
    see_bus(S_PC, "pc_wrap", 32'h0);
    bus_sel = SEL_W'(S_CS); c_sext = 32'h40; pc_en = 1; inc_pc = 1; step();
    pc_en = 0; inc_pc = 0;
    see_bus(S_PC, "pc_en_prio", 32'h40);
    inc_pc = 1; step(); inc_pc = 0;
    see_bus(S_PC, "pc_inc", 32'h41);

    // Z pair
    alu_result = 64'h0000_0001_8000_0000; z_en = 1; step(); z_en = 0;
    see_bus(S_ZHI, "zhi", 32'h1);
    see_bus(S_ZLO, "zlo", 32'h8000_0000);

    // read with ack in third wait cycle
    bus_sel = SEL_W'(S_CS); c_sext = 32'h1A5; mar_en = 1; step(); mar_en = 0;
    chk("mar_load", mem_addr, 9'h1A5);
    mem_read = 1; step(); mem_read = 0;
    chk("rd_req", mem_req, 1);
    chk("rd_we", mem_we, 0);
    chk("rd_busy", mem_busy, 1);
    chk("rd_addr", mem_addr, 9'h1A5);
    c_sext = 32'h0FF; mar_en = 1; step(); mar_en = 0;
    chk("rd_addr_held", mem_addr, 9'h1A5);
    c_sext = 32'h777; mem_write = 1; mdr_en = 1; step(); mem_write = 0; mdr_en = 0;
    chk("rd_we_ignored", mem_we, 0);
    chk("rd_done_early", mem_done, 0);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; step(); mem_ack = 0;
    chk("rd_done", mem_done, 1);
    chk("rd_idle", mem_busy, 0);
    chk("rd_mdr", mem_wdata, 32'hDEAD_BEEF);
    step();
    chk("rd_done_single", mem_done, 0);
    chk("rd_no_err", mem_err, 0);
    see_bus(S_MDR, "rd_mdr_bus", 32'hDEAD_BEEF);

    // write, ack in first wait cycle
    bus_sel = SEL_W'(S_CS); c_sext = 32'h55; mdr_en = 1; step(); mdr_en = 0;
    mem_write = 1; step(); mem_write = 0;
    chk("wr_req", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_wdata", mem_wdata, 32'h55);
    chk("wr_addr", mem_addr, 9'h0FF);
    mem_ack = 1; step(); mem_ack = 0;
    chk("wr_done", mem_done, 1);
    chk("wr_idle", mem_busy, 0);
    step();
    chk("wr_done_single", mem_done, 0);

    // timeout
    mem_rdata = 32'h0000_0BAD;
    mem_read = 1; step(); mem_read = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("to_no_done", mem_done, 0);
    end
    chk("to_busy_14", mem_busy, 1);
    chk("to_err_14", mem_err, 0);
    step();
    chk("to_err", mem_err, 1);
    chk("to_idle", mem_busy, 0);
    chk("to_done", mem_done, 0);
    see_bus(S_MDR, "to_mdr_kept", 32'h55);
    step();
    chk("to_done_after", mem_done, 0);
    chk("to_err_sticky", mem_err, 1);

    // clear then conflicting request
    clr = 0; step(); clr = 1;
    chk("err_cleared", mem_err, 0);
    mem_read = 1; mem_write = 1; step(); mem_read = 0; mem_write = 0;
    chk("both_err", mem_err, 1);
    chk("both_idle", mem_busy, 0);
    chk("both_noreq", mem_req, 0);

    // clear in the middle of a read
    bus_sel = SEL_W'(S_CS); c_sext = 32'h99; mdr_en = 1; step(); mdr_en = 0;
    mem_read = 1; step(); mem_read = 0;
    chk("mid_req", mem_req, 1);
    clr = 0; step(); clr = 1;
    chk("mid_req_drop", mem_req, 0);
    chk("mid_busy", mem_busy, 0);
    chk("mid_err", mem_err, 0);
    see_bus(S_MDR, "mid_mdr", 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
Parametrised next-generation processor datapath. Provides a NUM_REGS x WIDTH general register file, the special registers (PC, IR, Y, Z, HI, LO, MAR, MDR, OUT), and a single shared bus driven by an encoded source select. Adds a handshaked memory port with wait-state and timeout handling. Sits between the control unit/select-encode logic and the ALU and memory; the ALU is external and connects through the alu_a/alu_b/alu_result ports.

Parameters:
WIDTH, 32, datapath and bus width in bits
NUM_REGS, 16, number of general registers (power of two, >= 2)
ADDR_W, 9, memory address width; MAR holds bits [ADDR_W-1:0] of the bus
PC_STEP, 1, increment applied by inc_pc
TIMEOUT, 15, maximum cycles waiting for mem_ack before an error is raised
R0_BA, 1, if 1, R0 reads as zero on the bus while ba_out=1

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  synchronous active-low clear
bus_sel  in  SEL_W = clog2(NUM_REGS+8)  bus source: 0..NUM_REGS-1 = Rn, then HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN
ba_out  in  1  base-address mode for R0
reg_en  in  NUM_REGS  one-hot-or-zero general register load
hi_en, lo_en, y_en, z_en, pc_en, ir_en, mar_en, mdr_en, out_en  in  1 each  special register loads from the bus (z_en loads Z from alu_result)
inc_pc  in  1  PC <= PC + PC_STEP
mem_read, mem_write  in  1 each  single-cycle memory operation request pulses
c_sext  in  WIDTH  sign-extended constant (CSIGN source)
in_port  in  WIDTH  input port data (INPORT source)
alu_result  in  2*WIDTH  ALU result; Z captures it
alu_a  out  WIDTH  bus value (ALU operand A)
alu_b  out  WIDTH  Y register (ALU operand B)
bus  out  WIDTH  current bus value
ir  out  WIDTH  IR contents
out_port  out  WIDTH  OUT register
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  equals MAR
mem_wdata  out  WIDTH  equals MDR
mem_rdata  in  WIDTH  read data, valid with mem_ack
mem_ack  in  1  memory completion
mem_busy  out  1  memory FSM not IDLE
mem_done  out  1  one-cycle pulse on completion
mem_err  out  1  sticky error flag

Behaviour:
- Reset: clr=0 at a clock edge clears every register, the Z pair, MAR, MDR and OUT to 0; FSM goes to IDLE; mem_req, mem_we, mem_done and mem_err go to 0. Clear takes priority over every other input, including an operation in flight.
- Bus: purely combinational mux on bus_sel. Unused codes drive 0. Source 0 drives 0 when R0_BA=1 and ba_out=1.
- Loads: every enabled destination captures the bus at the same edge; multiple destinations may load together.
- PC: pc_en has priority over inc_pc. PC wraps modulo 2^WIDTH.
- Z: ZHI <= alu_result[2W-1:W] and ZLO <= alu_result[W-1:0] when z_en=1.
- Memory FSM states: IDLE, RD_WAIT, WR_WAIT.
  - In IDLE, mem_read=1 (with mem_write=0) goes to RD_WAIT next cycle; mem_write=1 (with mem_read=0) goes to WR_WAIT.
  - mem_read and mem_write both 1: neither is accepted; mem_err is set.
  - In a WAIT state, mem_req=1; mem_we=1 only in WR_WAIT. MAR is sampled at the request, not held.
  - RD_WAIT with mem_ack=1: MDR <= mem_rdata; return to IDLE; mem_done pulses the following cycle.
  - WR_WAIT with mem_ack=1: return to IDLE; mem_done pulses.
  - A wait counter starts at 0 on entry. If it reaches TIMEOUT without mem_ack: set mem_err, return to IDLE, no MDR update, no mem_done.
  - mem_read/mem_write pulses while busy are ignored.
  - mdr_en while busy is ignored; MDR remains under FSM control. mar_en while busy is permitted but does not alter the in-flight address.
  - Minimum operation: 1 request cycle, then mem_done on the cycle after ack (ack in the first WAIT cycle gives latency 2).
- mem_err clears only on clr.

Test Plan:
- Reset with all registers preloaded: drive clr=0 for one edge -> all outputs 0, FSM IDLE; repeat mid-RD_WAIT -> mem_req drops next cycle, MDR=0.
- Load R5 from c_sext=0xFFFF_FFF0 via bus_sel=CSIGN, then bus_sel=5 with y_en -> alu_b=0xFFFF_FFF0; R0=0x1234 with ba_out=1 -> bus=0, with ba_out=0 -> bus=0x1234.
- PC=0xFFFF_FFFF with inc_pc -> 0; pc_en and inc_pc together with bus=0x40 -> PC=0x40.
- MAR=0x1A5 with mem_read and ack after 3 cycles returning 0xDEADBEEF -> mem_addr=0x1A5, mem_we=0, MDR=0xDEADBEEF, single mem_done pulse; write with MDR=0x55 -> mem_we=1, mem_wdata=0x55.
- No ack for TIMEOUT=15 cycles -> mem_err=1, MDR unchanged, no mem_done; simultaneous read and write -> mem_err=1, FSM stays IDLE.
- z_en with alu_result=0x0000_0001_8000_0000 -> bus_sel=ZHI gives 1, bus_sel=ZLO gives 0x8000_0000.
